// File: rtl/vga_timing_gen.sv
// Pixel-clock video timing generator: H/V counters, sync/gate phase decode,
// and registered polarized Hsync/Vsync/Csync/Blank plus eol/eof pulses.
module vga_timing_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSyncL,
    input  logic [7:0]  Thsync,
    input  logic [7:0]  Thgdel,
    input  logic [15:0] Thgate,
    input  logic [15:0] Thlen,
    input  logic        VSyncL,
    input  logic [7:0]  Tvsync,
    input  logic [7:0]  Tvgdel,
    input  logic [15:0] Tvgate,
    input  logic [15:0] Tvlen,
    input  logic        CSyncL,
    input  logic        BlankL,
    output logic        eol,
    output logic        eof,
    output logic        gate,
    output logic        Hsync,
    output logic        Vsync,
    output logic        Csync,
    output logic        Blank
);

    logic [15:0] hcnt;
    logic [15:0] vcnt;
    logic        line_end;
    logic        frame_end;

    logic [16:0] h_gate_beg;
    logic [16:0] h_gate_end;
    logic [16:0] v_gate_beg;
    logic [16:0] v_gate_end;

    logic        hs;
    logic        vs;
    logic        hgate;
    logic        vgate;

    // >= rather than == so a shortened period mid-line wraps at once
    always_comb begin
        line_end  = (hcnt >= Thlen);
        frame_end = (vcnt >= Tvlen);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= 16'd0;
        end else if (line_end) begin
            hcnt <= 16'd0;
        end else begin
            hcnt <= hcnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vcnt <= 16'd0;
        end else if (line_end) begin
            if (frame_end) begin
                vcnt <= 16'd0;
            end else begin
                vcnt <= vcnt + 16'd1;
            end
        end
    end

    // Visible window bounds; 17 bits holds the largest possible sum
    always_comb begin
        h_gate_beg = {9'd0, Thsync} + {9'd0, Thgdel} + 17'd2;
        h_gate_end = h_gate_beg + {1'b0, Thgate};
        v_gate_beg = {9'd0, Tvsync} + {9'd0, Tvgdel} + 17'd2;
        v_gate_end = v_gate_beg + {1'b0, Tvgate};
    end

    always_comb begin
        hs    = (hcnt <= {8'd0, Thsync});
        vs    = (vcnt <= {8'd0, Tvsync});
        hgate = ({1'b0, hcnt} >= h_gate_beg) &&
                ({1'b0, hcnt} <= h_gate_end);
        vgate = ({1'b0, vcnt} >= v_gate_beg) &&
                ({1'b0, vcnt} <= v_gate_end);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eol   <= 1'b0;
            eof   <= 1'b0;
            gate  <= 1'b0;
            Hsync <= HSyncL;
            Vsync <= VSyncL;
            Csync <= CSyncL;
            Blank <= ~BlankL;
        end else begin
            eol   <= line_end;
            eof   <= line_end & frame_end;
            gate  <= hgate & vgate;
            Hsync <= hs ^ HSyncL;
            Vsync <= vs ^ VSyncL;
            Csync <= (hs | vs) ^ CSyncL;
            Blank <= ~(hgate & vgate) ^ BlankL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed and randomized timings checked
// against a closed-form position model (pixel/line from elapsed clocks).
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        HSyncL = 1'b0;
    logic [7:0]  Thsync = 8'd1;
    logic [7:0]  Thgdel = 8'd1;
    logic [15:0] Thgate = 16'd3;
    logic [15:0] Thlen = 16'd9;
    logic        VSyncL = 1'b0;
    logic [7:0]  Tvsync = 8'd0;
    logic [7:0]  Tvgdel = 8'd0;
    logic [15:0] Tvgate = 16'd1;
    logic [15:0] Tvlen = 16'd4;
    logic        CSyncL = 1'b0;
    logic        BlankL = 1'b0;
    logic        eol;
    logic        eof;
    logic        gate;
    logic        Hsync;
    logic        Vsync;
    logic        Csync;
    logic        Blank;

    int total = 0;
    int bad = 0;

    vga_timing_gen dut (
        .clk(clk), .rst(rst),
        .HSyncL(HSyncL), .Thsync(Thsync), .Thgdel(Thgdel),
        .Thgate(Thgate), .Thlen(Thlen),
        .VSyncL(VSyncL), .Tvsync(Tvsync), .Tvgdel(Tvgdel),
        .Tvgate(Tvgate), .Tvlen(Tvlen),
        .CSyncL(CSyncL), .BlankL(BlankL),
        .eol(eol), .eof(eof), .gate(gate),
        .Hsync(Hsync), .Vsync(Vsync), .Csync(Csync), .Blank(Blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_pol(input logic p);
        HSyncL = p;
        VSyncL = p;
        CSyncL = p;
        BlankL = p;
    endtask

    // Hold reset for two edges, check idle outputs, release at negedge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({tag, "_rst_eol"}, eol, 1'b0);
        chk({tag, "_rst_eof"}, eof, 1'b0);
        chk({tag, "_rst_gate"}, gate, 1'b0);
        chk({tag, "_rst_hs"}, Hsync, HSyncL);
        chk({tag, "_rst_vs"}, Vsync, VSyncL);
        chk({tag, "_rst_cs"}, Csync, CSyncL);
        chk({tag, "_rst_blank"}, Blank, ~BlankL);
        rst = 1'b0;
    endtask

    // Expected outputs for the n-th clock of a run that started at
    // pixel 0 of line vbase, derived straight from the phase rules.
    task automatic check_pos(input int n, input int vbase, input string tag);
        int hl, vl, h, v, gb, ge, vb, ve;
        logic hs, vs, hg, vg, le, ef;
        hl = int'(Thlen) + 1;
        vl = int'(Tvlen) + 1;
        h  = n % hl;
        v  = (vbase + n / hl) % vl;
        gb = int'(Thsync) + int'(Thgdel) + 2;
        ge = gb + int'(Thgate);
        vb = int'(Tvsync) + int'(Tvgdel) + 2;
        ve = vb + int'(Tvgate);
        hs = (h <= int'(Thsync));
        vs = (v <= int'(Tvsync));
        hg = (h >= gb) && (h <= ge);
        vg = (v >= vb) && (v <= ve);
        le = (h == hl - 1);
        ef = le && (v == vl - 1);
        chk({tag, "_eol"}, eol, le);
        chk({tag, "_eof"}, eof, ef);
        chk({tag, "_gate"}, gate, hg & vg);
        chk({tag, "_hsync"}, Hsync, hs ^ HSyncL);
        chk({tag, "_vsync"}, Vsync, vs ^ VSyncL);
        chk({tag, "_csync"}, Csync, (hs | vs) ^ CSyncL);
        chk({tag, "_blank"}, Blank, ~(hg & vg) ^ BlankL);
    endtask

    task automatic run_span(input int cnt, input int vbase, input string tag,
                            output int gates, output int eofs, output int eols);
        gates = 0;
        eofs  = 0;
        eols  = 0;
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_pos(i, vbase, tag);
            gates += int'(gate);
            eofs  += int'(eof);
            eols  += int'(eol);
        end
    endtask

    initial begin
        int g, f, l;

        // H and V timing, active-high then active-low polarities
        for (int p = 0; p < 2; p++) begin
            set_pol(p[0]);
            do_reset(p == 0 ? "hv0" : "hv1");
            run_span(50, 0, p == 0 ? "hv0" : "hv1", g, f, l);
            chk_int("frame_gates", g, 8);
            chk_int("frame_eofs", f, 1);
            chk_int("frame_eols", l, 5);
            run_span(50, 0, p == 0 ? "hv0b" : "hv1b", g, f, l);
            chk_int("frame2_gates", g, 8);
        end

        // Reset in the middle of line 3
        set_pol(1'b0);
        do_reset("mid");
        run_span(34, 0, "mid_pre", g, f, l);
        do_reset("mid");
        run_span(20, 0, "mid_post", g, f, l);
        chk_int("mid_post_eols", l, 2);

        // Period shortened while hcnt sits at 8
        do_reset("wrap");
        run_span(8, 0, "wrap_pre", g, f, l);
        Thlen = 16'd5;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("wrap_eol", eol, (i % 6) == 0);
        end

        // Randomized timings and polarities
        for (int r = 0; r < 4; r++) begin
            Thsync = 8'($urandom_range(0, 5));
            Thgdel = 8'($urandom_range(0, 5));
            Thgate = 16'($urandom_range(0, 12));
            Thlen  = 16'($urandom_range(4, 30));
            Tvsync = 8'($urandom_range(0, 2));
            Tvgdel = 8'($urandom_range(0, 2));
            Tvgate = 16'($urandom_range(0, 4));
            Tvlen  = 16'($urandom_range(2, 9));
            HSyncL = 1'($urandom);
            VSyncL = 1'($urandom);
            CSyncL = 1'($urandom);
            BlankL = 1'($urandom);
            do_reset("rnd");
            run_span(2 * (int'(Thlen) + 1) * (int'(Tvlen) + 1) + 7,
                     0, "rnd", g, f, l);
            chk_int("rnd_eofs", f, 2);
        end

        // Maximum line length and gate width after reaching line 2
        set_pol(1'b0);
        Thsync = 8'd1;
        Thgdel = 8'd1;
        Thgate = 16'd3;
        Thlen  = 16'd9;
        Tvsync = 8'd0;
        Tvgdel = 8'd0;
        Tvgate = 16'hFFFF;
        Tvlen  = 16'hFFFF;
        do_reset("max");
        run_span(20, 0, "max_pre", g, f, l);
        Thlen  = 16'hFFFF;
        Thgate = 16'hFFFF;
        run_span(65540, 2, "max", g, f, l);
        chk_int("max_gates", g, 65532);
        chk_int("max_eols", l, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
